// File: rtl/rst_seq_pkg.sv
// Shared types and codes for the reset sequencer: FSM states and reset-cause encodings.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'b00,
        REL_CORE = 2'b01,
        RUN      = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

endpackage

// File: rtl/rst_seq_cnt.sv
// Cycle counter with synchronous clear, enable and a terminal-count compare.
module rst_seq_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: reset and clear dominate enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == term);

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds rst_core after the last reset source, then releases
// rst_periph a fixed stagger later; all outputs come straight from flops.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       rst_req,
    input  logic       sw_rst_req,
    output logic       sw_rst_ack,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 2**CNT_W) begin : g_bad_hold
        $error("rst_sequencer: HOLD_CYCLES out of range 1..2**CNT_W");
    end
    if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > 2**CNT_W) begin : g_bad_stagger
        $error("rst_sequencer: STAGGER_CYCLES out of range 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_TERM = CNT_W'(STAGGER_CYCLES - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic [CNT_W-1:0] term_s;
    logic [CNT_W-1:0] cnt_s;
    logic             tc_s;

    rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (pclk),
        .rst  (preset),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .term (term_s),
        .cnt  (cnt_s),
        .tc   (tc_s)
    );

    // Next-state and counter control; any request restarts the sequence from HOLD.
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        term_s       = HOLD_TERM;
        if (rst_req || sw_rst_req) begin
            next_state_s = HOLD;
            cnt_clr_s    = 1'b1;
        end else begin
            case (state_r)
                HOLD: begin
                    term_s = HOLD_TERM;
                    if (tc_s) begin
                        next_state_s = REL_CORE;
                        cnt_clr_s    = 1'b1;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
                REL_CORE: begin
                    term_s = STAG_TERM;
                    if (tc_s) begin
                        next_state_s = RUN;
                        cnt_clr_s    = 1'b1;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
                RUN: begin
                    next_state_s = RUN;
                end
                default: begin
                    next_state_s = HOLD;
                    cnt_clr_s    = 1'b1;
                end
            endcase
        end
    end

    // State and output flops; outputs decode the next state so they track state_r exactly.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r    <= HOLD;
            rst_core   <= 1'b1;
            rst_periph <= 1'b1;
            rst_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
            rst_cause  <= CAUSE_POR;
        end else begin
            state_r    <= next_state_s;
            rst_core   <= (next_state_s == HOLD);
            rst_periph <= (next_state_s != RUN);
            rst_done   <= (next_state_s == RUN);
            sw_rst_ack <= sw_rst_req;
            if (rst_req) begin
                rst_cause <= CAUSE_EXT;
            end else if (sw_rst_req) begin
                rst_cause <= CAUSE_SW;
            end else begin
                rst_cause <= rst_cause;
            end
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a table of {inputs, cycles, expected outputs}
// plus per-cycle sequences for mid-sequence restart and release timing.
module tb_rst_sequencer;

    logic       pclk;
    logic       preset;
    logic       rst_req;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       rst_core;
    logic       rst_periph;
    logic       rst_done;
    logic [1:0] rst_cause;

    int total;
    int bad;

    rst_sequencer dut (
        .pclk       (pclk),
        .preset     (preset),
        .rst_req    (rst_req),
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack),
        .rst_core   (rst_core),
        .rst_periph (rst_periph),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // exp = {rst_core, rst_periph, rst_done, sw_rst_ack, rst_cause}
    typedef struct {
        int         n;
        logic       p;
        logic       r;
        logic       s;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[21];

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic p, input logic r, input logic s);
        preset     = p;
        rst_req    = r;
        sw_rst_req = s;
    endtask

    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {rst_core, rst_periph, rst_done, sw_rst_ack, rst_cause};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b (core,periph,done,ack,cause)", name, got, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b0, 1'b0);

        vecs[0]  = '{3,  1'b1, 1'b0, 1'b0, 6'b110000}; // power-on reset
        vecs[1]  = '{15, 1'b0, 1'b0, 1'b0, 6'b110000}; // still holding
        vecs[2]  = '{1,  1'b0, 1'b0, 1'b0, 6'b010000}; // edge 16: core released
        vecs[3]  = '{3,  1'b0, 1'b0, 1'b0, 6'b010000};
        vecs[4]  = '{1,  1'b0, 1'b0, 1'b0, 6'b001000}; // edge 20: RUN
        vecs[5]  = '{5,  1'b0, 1'b0, 1'b0, 6'b001000};
        vecs[6]  = '{10, 1'b0, 1'b1, 1'b0, 6'b110001}; // external stretch
        vecs[7]  = '{15, 1'b0, 1'b0, 1'b0, 6'b110001};
        vecs[8]  = '{1,  1'b0, 1'b0, 1'b0, 6'b010001};
        vecs[9]  = '{3,  1'b0, 1'b0, 1'b0, 6'b010001};
        vecs[10] = '{1,  1'b0, 1'b0, 1'b0, 6'b001001};
        vecs[11] = '{1,  1'b0, 1'b0, 1'b1, 6'b110110}; // software reset + ack
        vecs[12] = '{1,  1'b0, 1'b0, 1'b0, 6'b110010};
        vecs[13] = '{14, 1'b0, 1'b0, 1'b0, 6'b110010};
        vecs[14] = '{1,  1'b0, 1'b0, 1'b0, 6'b010010};
        vecs[15] = '{4,  1'b0, 1'b0, 1'b0, 6'b001010};
        vecs[16] = '{1,  1'b0, 1'b1, 1'b1, 6'b110101}; // both requests: ext wins, ack
        vecs[17] = '{1,  1'b0, 1'b0, 1'b0, 6'b110001};
        vecs[18] = '{20, 1'b0, 1'b0, 1'b0, 6'b001001};
        vecs[19] = '{1,  1'b1, 1'b0, 1'b1, 6'b110000}; // preset beats sw request
        vecs[20] = '{1,  1'b0, 1'b0, 1'b0, 6'b110000};

        for (int i = 0; i < 21; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                drive(vecs[i].p, vecs[i].r, vecs[i].s);
                step();
            end
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Mid-sequence restart: sw request at cnt=10 in HOLD, then at cnt=2 in REL_CORE.
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        repeat (10) step();
        drive(1'b0, 1'b0, 1'b1);
        step();
        chk("restart_hold_ack", 6'b110110);
        drive(1'b0, 1'b0, 1'b0);
        repeat (16) step();
        chk("restart_in_rel", 6'b010010);
        repeat (2) step();
        drive(1'b0, 1'b0, 1'b1);
        step();
        chk("restart_rel_core_reasserts", 6'b110110);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("restart_edge%0d", k),
                {(k < 16) ? 1'b1 : 1'b0, (k < 20) ? 1'b1 : 1'b0,
                 (k >= 20) ? 1'b1 : 1'b0, 1'b0, 2'b10});
        end

        // Preset mid-REL_CORE restarts immediately, then count resumes from zero.
        repeat (3) step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        chk("preset_in_run", 6'b110000);
        drive(1'b0, 1'b0, 1'b0);
        repeat (17) step();
        drive(1'b1, 1'b1, 1'b1);
        step();
        chk("preset_in_rel", 6'b110000);
        drive(1'b0, 1'b0, 1'b0);
        repeat (16) step();
        chk("after_preset_rel", 6'b010000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, setting the number of cycles rst_core is held after the last reset source is released.
REQ-002 The block SHALL have parameter STAGGER_CYCLES, default 4, setting the number of cycles between rst_core release and rst_periph release.
REQ-003 The block SHALL have parameter CNT_W, default 8, setting the width of the internal cycle counter.
REQ-004 The block SHALL have port pclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port preset, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port rst_req, input, 1 bit, an external reset request, level-sensitive.
REQ-007 The block SHALL have port sw_rst_req, input, 1 bit, a software reset request, one-cycle pulse.
REQ-008 The block SHALL have port sw_rst_ack, output, 1 bit, a one-cycle acknowledge of an accepted sw_rst_req.
REQ-009 The block SHALL have port rst_core, output, 1 bit, the active-high core-domain reset.
REQ-010 The block SHALL have port rst_periph, output, 1 bit, the active-high peripheral-domain reset.
REQ-011 The block SHALL have port rst_done, output, 1 bit, high only while the sequence is complete (RUN state).
REQ-012 The block SHALL have port rst_cause, output, 2 bits, the last reset source: 00 = preset, 01 = rst_req, 10 = software.

Function
REQ-013 The block SHALL implement FSM states HOLD, REL_CORE and RUN, with a CNT_W-bit counter cnt.
REQ-014 In HOLD, the block SHALL drive rst_core=1, rst_periph=1 and rst_done=0.
REQ-015 In REL_CORE, the block SHALL drive rst_core=0, rst_periph=1 and rst_done=0.
REQ-016 In RUN, the block SHALL drive rst_core=0, rst_periph=0 and rst_done=1.
REQ-017 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-018 In HOLD with no request, the block SHALL increment cnt each edge; at cnt==HOLD_CYCLES-1 it SHALL go to REL_CORE with cnt<=0.
REQ-019 In REL_CORE with no request, the block SHALL increment cnt; at cnt==STAGGER_CYCLES-1 it SHALL go to RUN with cnt<=0.
REQ-020 RUN SHALL hold indefinitely until a request arrives.
REQ-021 While rst_req=1 in any state, the block SHALL go to or stay in HOLD with cnt<=0 and rst_cause<=01 (stretch: counting starts on the first edge with rst_req=0).
REQ-022 On sw_rst_req=1 with rst_req=0 in any state, the block SHALL go to HOLD with cnt<=0 and rst_cause<=10.
REQ-023 sw_rst_ack SHALL pulse high exactly one cycle, on the edge after any sampled sw_rst_req=1, including when rst_req is also high.
REQ-024 When rst_req and sw_rst_req are both high, rst_req SHALL have priority: rst_cause<=01, with the ack still issued.
REQ-025 A request arriving mid-count in HOLD or REL_CORE SHALL restart the full sequence from HOLD with cnt=0; rst_core SHALL re-assert on the next edge.
REQ-026 rst_cause SHALL hold its value until the next reset source.
REQ-027 cnt SHALL never wrap; HOLD_CYCLES and STAGGER_CYCLES SHALL each be in the range 1..2**CNT_W, with an elaboration-time check.
REQ-028 With defaults: rst_core SHALL fall after the 16th edge with no source active, and rst_periph and rst_done SHALL change after the 20th.

Reset
REQ-029 While preset=1 at a rising edge: state<=HOLD, cnt<=0, rst_core=1, rst_periph=1, rst_done=0, sw_rst_ack=0, rst_cause<=00.
REQ-030 preset SHALL override rst_req and sw_rst_req, and no ack SHALL be generated during preset.
REQ-031 preset asserted mid-sequence or in RUN SHALL take effect on that edge and restart the sequence.

Structure
REQ-032 Package rst_seq_pkg SHALL hold the state enum (HOLD, REL_CORE, RUN) and the rst_cause codes (CAUSE_POR, CAUSE_EXT, CAUSE_SW).
REQ-033 Sub-module rst_seq_cnt SHALL be a parameterised CNT_W counter with clear, enable and terminal-count compare, instantiated once.

Verification
REQ-034 Power-on: preset high 3 cycles then low -> rst_core falls after edge 16, rst_periph and rst_done change after edge 20, rst_cause=00.
REQ-035 External stretch: in RUN, rst_req high 10 cycles -> rst_core high throughout plus 16 cycles after release; rst_periph released 4 cycles later; rst_cause=01.
REQ-036 Software reset: in RUN, one-cycle sw_rst_req -> sw_rst_ack pulses 1 cycle, rst_core=1 on the next edge, full 16+4 sequence, rst_cause=10.
REQ-037 Mid-sequence restart: sw_rst_req at cnt=10 in HOLD, then at cnt=2 in REL_CORE -> each restarts at cnt=0; rst_done first rises 20 cycles after the last request.
REQ-038 Simultaneous requests: rst_req and sw_rst_req together -> sw_rst_ack=1 for 1 cycle, rst_cause=01, state HOLD.
REQ-039 Reset priority: preset high together with sw_rst_req in RUN -> no ack, rst_cause=00, all outputs at their reset values.
